// File: rtl/tcm_ctrl_pkg.sv
// Shared widths, response entry layout and address range check for the
// TCM port controller.
package tcm_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_NUM_WMASKS = 8;
  localparam int DEF_TAG_WIDTH  = 4;
  localparam int DEF_RESP_DEPTH = 4;

  typedef struct packed {
    logic [DEF_TAG_WIDTH-1:0]  tag;
    logic                      error;
    logic [DEF_DATA_WIDTH-1:0] data;
  } resp_entry_t;

  // Bits [2:0] select a byte within the word and never affect the range.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int unsigned addr_width);
    return (addr >> (addr_width + 3)) == 32'd0;
  endfunction

endpackage

// File: rtl/tcm_resp_fifo.sv
// Synchronous response FIFO with wrap-around pointers and an occupancy count.
// The head reads as zero while empty.
module tcm_resp_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 69,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Push and pop on the same edge leave the count unchanged, even when full.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/tcm_port_ctrl.sv
// Front-end for one TCM SRAM port: request decode, one-entry pending stage
// that captures read data after the macro's negedge access, and a credited
// response FIFO.
module tcm_port_ctrl
  import tcm_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_WMASKS = DEF_NUM_WMASKS,
  parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
  parameter int RESP_DEPTH = DEF_RESP_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_accept_o,
  input  logic [31:0]           req_addr_i,
  input  logic [NUM_WMASKS-1:0] req_wr_i,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  input  logic [TAG_WIDTH-1:0]  req_tag_i,
  output logic                  resp_valid_o,
  input  logic                  resp_accept_i,
  output logic [DATA_WIDTH-1:0] resp_data_o,
  output logic [TAG_WIDTH-1:0]  resp_tag_o,
  output logic                  resp_error_o,
  output logic                  ram_csb_o,
  output logic                  ram_web_o,
  output logic [NUM_WMASKS-1:0] ram_wmask_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_din_o,
  input  logic [DATA_WIDTH-1:0] ram_dout_i
);

  localparam int ENTRY_W = TAG_WIDTH + 1 + DATA_WIDTH;
  localparam int CNT_W   = $clog2(RESP_DEPTH + 1);

  logic                 pend_valid;
  logic                 pend_read;
  logic                 pend_error;
  logic [TAG_WIDTH-1:0] pend_tag;

  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [ENTRY_W-1:0]   fifo_wdata;
  logic [ENTRY_W-1:0]   fifo_rdata;
  logic [CNT_W:0]       credits;

  logic                 in_range;
  logic                 fire;
  logic                 access;

  // Credits cover both the pending stage and the queue, so a push always has room.
  assign credits      = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(pend_valid);
  assign req_accept_o = !rst_i && (credits < (CNT_W + 1)'(RESP_DEPTH));

  assign in_range = addr_in_range(req_addr_i, ADDR_WIDTH);
  assign fire     = req_valid_i && req_accept_o;
  assign access   = fire && in_range;

  assign ram_csb_o   = !access;
  assign ram_web_o   = !(access && (|req_wr_i));
  assign ram_addr_o  = req_addr_i[ADDR_WIDTH+2:3];
  assign ram_wmask_o = req_wr_i;
  assign ram_din_o   = req_data_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_valid <= 1'b0;
      pend_tag   <= '0;
      pend_read  <= 1'b0;
      pend_error <= 1'b0;
    end else begin
      pend_valid <= fire;
      pend_tag   <= req_tag_i;
      pend_read  <= ~|req_wr_i;
      pend_error <= !in_range;
    end
  end

  // ram_dout_i is only valid at this edge; write and error entries never see it.
  assign fifo_push  = pend_valid && (!fifo_full || fifo_pop);
  assign fifo_wdata = {pend_tag, pend_error,
                       (pend_read && !pend_error) ? ram_dout_i : {DATA_WIDTH{1'b0}}};
  assign fifo_pop   = resp_valid_o && resp_accept_i;

  tcm_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_resp_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign resp_valid_o = !fifo_empty;
  assign {resp_tag_o, resp_error_o, resp_data_o} = fifo_rdata;

endmodule
